// File: rtl/brush_stamp_writer.sv
// brush_stamp_writer: emits one index-RAM write per clock for a clipped square brush stamp or a full-screen clear
// Ports: iCLK/iRST clock and sync reset; iCMD_* command handshake and fields (clear, x, y, half-width r, colour);
//        oADDR/oDATA/oWREN index-RAM write port; oBUSY/oDONE/oCMD_READY status.
module brush_stamp_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCMD_VALID,
    output logic        oCMD_READY,
    input  logic        iCMD_CLEAR,
    input  logic [9:0]  iCMD_X,
    input  logic [8:0]  iCMD_Y,
    input  logic [5:0]  iCMD_R,
    input  logic [7:0]  iCMD_COLOR,
    output logic [31:0] oADDR,
    output logic [31:0] oDATA,
    output logic        oWREN,
    output logic        oBUSY,
    output logic        oDONE
);
    typedef enum logic [2:0] {IDLE, SETUP, STAMP, CLEAR, DONE} state_t;
    state_t r_state, w_next;
    logic              r_clear;
    logic [9:0]        r_x, r_x0, r_x1, r_cx;
    logic [8:0]        r_y, r_y1, r_cy;
    logic [5:0]        r_r;
    logic [7:0]        r_color;
    logic [ADDR_W-1:0] r_base;
    logic              w_accept, w_off, w_last_px, w_last_clr;
    logic [10:0]       w_xhi;
    logic [9:0]        w_yhi, w_x0, w_x1;
    logic [8:0]        w_y0, w_y1;
    // Clip bounds use widened sums and compare-before-subtract so nothing wraps at the screen edges
    always_comb begin
        w_accept   = iCMD_VALID && oCMD_READY;
        w_off      = (r_x >= 10'(H_RES)) || (r_y >= 9'(V_RES));
        w_xhi      = {1'b0, r_x} + {5'b0, r_r};
        w_yhi      = {1'b0, r_y} + {4'b0, r_r};
        w_x0       = ({4'b0, r_r} > r_x) ? 10'd0 : r_x - {4'b0, r_r};
        w_y0       = ({3'b0, r_r} > r_y) ? 9'd0 : r_y - {3'b0, r_r};
        w_x1       = (w_xhi > 11'(H_RES - 1)) ? 10'(H_RES - 1) : w_xhi[9:0];
        w_y1       = (w_yhi > 10'(V_RES - 1)) ? 9'(V_RES - 1) : w_yhi[8:0];
        w_last_px  = (r_cx == r_x1) && (r_cy == r_y1);
        w_last_clr = r_base == ADDR_W'(H_RES * V_RES - 1);
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? SETUP : IDLE;
            SETUP:   w_next = r_clear ? CLEAR : (w_off ? DONE : STAMP);
            STAMP:   w_next = w_last_px ? DONE : STAMP;
            CLEAR:   w_next = w_last_clr ? DONE : CLEAR;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= IDLE;
        else      r_state <= w_next;
    end
    // Status and write strobe lag the state by one register stage, so the write issued in a
    // STAMP/CLEAR cycle appears on the port the following cycle.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oADDR      <= '0;
            oDATA      <= '0;
            oWREN      <= 1'b0;
            oDONE      <= 1'b0;
            oBUSY      <= 1'b0;
            oCMD_READY <= 1'b1;
        end else begin
            oWREN      <= (r_state == STAMP) || (r_state == CLEAR);
            oDONE      <= r_state == DONE;
            oCMD_READY <= (r_state == IDLE) && !w_accept;
            oBUSY      <= !((r_state == IDLE) && !w_accept);
            if (w_accept) begin
                r_clear <= iCMD_CLEAR;
                r_x     <= iCMD_X;
                r_y     <= iCMD_Y;
                r_r     <= iCMD_R;
                r_color <= iCMD_COLOR;
            end
            if (r_state == SETUP) begin
                r_x0   <= w_x0;
                r_x1   <= w_x1;
                r_y1   <= w_y1;
                r_cx   <= w_x0;
                r_cy   <= w_y0;
                r_base <= r_clear ? '0 : ADDR_W'(w_y0 * H_RES);
            end
            if (r_state == STAMP) begin
                oADDR <= 32'(r_base + ADDR_W'(r_cx));
                oDATA <= 32'(r_color);
                r_cx  <= (r_cx == r_x1) ? r_x0 : r_cx + 10'd1;
                if (r_cx == r_x1) begin
                    r_cy   <= r_cy + 9'd1;
                    r_base <= r_base + ADDR_W'(H_RES);
                end
            end
            if (r_state == CLEAR) begin
                oADDR  <= 32'(r_base);
                oDATA  <= 32'(r_color);
                r_base <= r_base + 1'b1;
            end
        end
    end
endmodule
